// File: rtl/round_arbiter.sv
// Tug-of-war round sequencer: arm delay, go LED, first press after go wins, early press fouls.
// Latency: 3 edges from button to registered outputs; no backpressure, awards held HOLD_CYCLES.
module round_arbiter #(
    parameter int CLOCK_FREQ   = 12000000,
    parameter int ARM_CYCLES   = CLOCK_FREQ / 2,
    parameter int RESP_TIMEOUT = 2 * CLOCK_FREQ,
    parameter int HOLD_CYCLES  = CLOCK_FREQ / 4 + 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_in,
    input  logic       p1_in,
    input  logic       p2_in,
    input  logic       w_done_in,
    output logic       w1_out,
    output logic       w2_out,
    output logic       go_led_out,
    output logic [3:0] round_cntr_out
);
    localparam int MAX_AR  = (ARM_CYCLES > RESP_TIMEOUT) ? ARM_CYCLES : RESP_TIMEOUT;
    localparam int MAX_CNT = (MAX_AR > HOLD_CYCLES) ? MAX_AR : HOLD_CYCLES;
    localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CW-1:0] ARM_LOAD  = CW'(ARM_CYCLES - 1);
    localparam logic [CW-1:0] RESP_LOAD = CW'(RESP_TIMEOUT - 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT,
        ST_AWARD,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    sync1_q, sync1_d;
    logic [2:0]    sync2_q, sync2_d;
    logic [2:0]    sync3_q, sync3_d;
    logic          w1_q, w1_d;
    logic          w2_q, w2_d;
    logic          go_q, go_d;
    logic [3:0]    round_q, round_d;
    logic [2:0]    evt;
    logic          ev_start, ev_p1_only, ev_p2_only, ev_both;

    always_comb begin
        // Bit 0 start, bit 1 player 1, bit 2 player 2; rising edge seen after two sync stages.
        sync1_d    = {p2_in, p1_in, start_in};
        sync2_d    = sync1_q;
        sync3_d    = sync2_q;
        evt        = sync2_q & ~sync3_q;
        ev_start   = evt[0];
        ev_p1_only = evt[1] & ~evt[2];
        ev_p2_only = evt[2] & ~evt[1];
        ev_both    = evt[1] & evt[2];

        state_d = state_q;
        cnt_d   = cnt_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        round_d = round_q;

        case (state_q)
            ST_IDLE: begin
                if (ev_start) begin
                    state_d = ST_ARM;
                    cnt_d   = ARM_LOAD;
                end
            end
            ST_ARM: begin
                if (ev_p1_only) begin
                    state_d = ST_AWARD;
                    cnt_d   = HOLD_LOAD;
                    w2_d    = 1'b1;
                end else if (ev_p2_only) begin
                    state_d = ST_AWARD;
                    cnt_d   = HOLD_LOAD;
                    w1_d    = 1'b1;
                end else if (ev_both) begin
                    cnt_d = ARM_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = ST_WAIT;
                    cnt_d   = RESP_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WAIT: begin
                if (ev_p1_only) begin
                    state_d = ST_AWARD;
                    cnt_d   = HOLD_LOAD;
                    w1_d    = 1'b1;
                end else if (ev_p2_only) begin
                    state_d = ST_AWARD;
                    cnt_d   = HOLD_LOAD;
                    w2_d    = 1'b1;
                end else if (ev_both || cnt_q == '0) begin
                    state_d = ST_ARM;
                    cnt_d   = ARM_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_AWARD: begin
                if (cnt_q == '0) begin
                    state_d = ST_ARM;
                    cnt_d   = ARM_LOAD;
                    w1_d    = 1'b0;
                    w2_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                w1_d = 1'b0;
                w2_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                w1_d    = 1'b0;
                w2_d    = 1'b0;
            end
        endcase

        // Game over from the winner block truncates any award in flight.
        if (state_q != ST_IDLE && w_done_in) begin
            state_d = ST_DONE;
            w1_d    = 1'b0;
            w2_d    = 1'b0;
        end

        if (state_d == ST_AWARD && state_q != ST_AWARD && round_q != 4'd15) begin
            round_d = round_q + 4'd1;
        end

        go_d = (state_d == ST_WAIT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            w1_q    <= 1'b0;
            w2_q    <= 1'b0;
            go_q    <= 1'b0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sync3_q <= sync3_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            go_q    <= go_d;
            round_q <= round_d;
        end
    end

    assign w1_out         = w1_q;
    assign w2_out         = w2_q;
    assign go_led_out     = go_q;
    assign round_cntr_out = round_q;
endmodule
